dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the NPC core: the target end of the load/store interface that the execute stage's memory controller drives. It accepts one request at a time over a valid/ready handshake, models a fixed access latency with a countdown counter, and performs byte/half/word writes with lane merging or sign/zero-extended reads on an internal word array. It returns the result over a second valid/ready handshake. It replaces a zero-latency combinational memory so that stall and handshake behaviour can be exercised in the pipeline.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 2: cycles spent in WAIT between request acceptance and the access edge; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; equals (state == IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for sb/sh.
- req_mop  in  3  RV32 funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu. For stores only 000/001/010 are legal.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  the request was illegal and had no effect.

## Operation

- FSM states:
  - IDLE → WAIT on req_valid & req_ready. At that edge, latch wen/addr/wdata/mop and set cnt = LATENCY-1.
  - WAIT with cnt != 0: cnt decrements.
  - WAIT with cnt == 0: perform the access at this edge, register resp_rdata and resp_err, go to RESP.
  - RESP: hold outputs until resp_valid & resp_ready, then go to IDLE. RESP never goes straight back to WAIT; there is no request bypass.
- Request inputs need not be held after the accepting edge.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Lane = addr[1:0].
- Error conditions; any one sets resp_err = 1, suppresses the write, and forces rdata = 0:
  - addr[31:2] >= DEPTH_WORDS.
  - h/hu with addr[0] = 1.
  - w with addr[1:0] != 0.
  - mop in {011, 110, 111}.
  - a store with mop 100 or 101.
- Store:
  - sb writes byte wdata[7:0] into lane addr[1:0].
  - sh writes half wdata[15:0] into bytes addr[1]*2 and addr[1]*2+1.
  - sw writes the whole word.
  - Other bytes are preserved.
- Load: select the byte or half by lane.
  - b and h sign-extend to 32 bits.
  - bu and hu zero-extend.
  - w returns the whole word.
- Array contents are not reset.

## Timing

- Reset values: state IDLE, cnt 0, resp_valid 0, resp_rdata 0, resp_err 0. Hence req_ready is 1 once rst deasserts.
- Reset mid-operation: the transaction is abandoned.
  - A store not yet at its access edge leaves the array unchanged.
  - A pending response is dropped.
- Latency, with the handshake in cycle 0:
  - WAIT occupies cycles 1..LATENCY.
  - resp_valid rises in cycle LATENCY+1.
  - If resp_ready is high there, req_ready rises in cycle LATENCY+2.
  - Sustained throughput is one request per LATENCY+2 cycles.
- req_valid during WAIT or RESP is ignored; req_ready is 0 there.
- resp_ready high before resp_valid is legal and has no effect.
- Under backpressure, resp_rdata and resp_err are stable while resp_valid = 1.
- Read-after-write: a load accepted after a store's response sees the stored data.

## Test plan

- Reset, then sw 0x12345678 to 0x10 with LATENCY = 2 and resp_ready = 1 → handshake in cycle 0; resp_valid = 1 in cycle 3 only, with err = 0 and rdata = 0; req_ready = 0 in cycles 1–3 and 1 in cycle 4.
- Then sb 0x000000AB to 0x11 → lw 0x10 returns 0x1234AB78; lb 0x11 returns 0xFFFFFFAB; lbu 0x11 returns 0x000000AB.
- Then sh 0x00008001 to 0x12 → lw 0x10 returns 0x8001AB78; lh 0x12 returns 0xFFFF8001; lhu 0x12 returns 0x00008001.
- Errors:
  - lw 0x13 → err = 1, rdata 0.
  - sh 0x11 (data 0xFFFF) → err = 1; a following lw 0x10 still returns 0x8001AB78.
  - lw 0x1000 with DEPTH_WORDS = 1024 → err = 1.
  - mop 011 → err = 1.
- Backpressure: lw 0x10 with resp_ready = 0 for 5 cycles and req_valid held high throughout → resp_valid and rdata 0x8001AB78 stay stable; req_ready stays 0; no second request is accepted until the cycle after resp_ready goes high.
- Reset asserted asynchronously in cycle 1 (WAIT) of sw 0xDEADBEEF to 0x10 → resp_valid = 0 and req_ready = 1 immediately after reset; a following lw 0x10 returns 0x8001AB78.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY wait, byte/half/word
// access with lane merge on stores and sign/zero extension on loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_mop,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | latency countdown; access happens on the edge where cnt_q == 0
    // S_RESP | response held until consumer accepts
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mop_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic          out_of_range;
    logic          bad_mop;
    logic          err_d;
    logic [31:0]   load_d;
    logic [31:0]   rdata_d;
    logic [31:0]   wr_word_d;
    logic          access;

    assign word_idx     = addr_q[AW+1:2];
    assign lane         = addr_q[1:0];
    assign cur_word     = mem_q[word_idx];
    assign byte_v       = cur_word[{lane, 3'b000} +: 8];
    assign half_v       = cur_word[{lane[1], 4'b0000} +: 16];
    assign out_of_range = (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign access       = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_comb begin
        bad_mop = 1'b1;
        load_d  = '0;
        case (mop_q)
            3'b000: begin bad_mop = 1'b0;                         load_d = {{24{byte_v[7]}}, byte_v}; end
            3'b001: begin bad_mop = addr_q[0];                    load_d = {{16{half_v[15]}}, half_v}; end
            3'b010: begin bad_mop = (addr_q[1:0] != 2'b00);       load_d = cur_word; end
            3'b100: begin bad_mop = wen_q;                        load_d = {24'd0, byte_v}; end
            3'b101: begin bad_mop = wen_q | addr_q[0];            load_d = {16'd0, half_v}; end
            default: begin bad_mop = 1'b1;                        load_d = '0; end
        endcase
        err_d   = out_of_range | bad_mop;
        rdata_d = (wen_q || err_d) ? 32'd0 : load_d;
    end

    always_comb begin
        wr_word_d = cur_word;
        case (mop_q)
            3'b000:  wr_word_d[{lane, 3'b000} +: 8]     = wdata_q[7:0];
            3'b001:  wr_word_d[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            3'b010:  wr_word_d = wdata_q;
            default: wr_word_d = cur_word;
        endcase
    end

    // Array has no reset; a reset before the access edge clears state_q, so no write occurs.
    always_ff @(posedge clk) begin
        if (access && wen_q && !err_d) begin
            mem_q[word_idx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mop_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        mop_q   <= req_mop;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q      <= rdata_d;
                        err_q        <= err_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS = 1024, LATENCY = 2).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_mop = 3'b010;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        er;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mop    (req_mop),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transaction with resp_ready high; inputs driven and sampled on the falling edge.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] mop, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_mop   = mop;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mop   = 3'b111;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);

        // Cycle-accurate sw 0x12345678 -> 0x10
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678; req_mop = 3'b010;
        chk("c0_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("c1_req_ready", 32'(req_ready), 32'd0);
        chk("c1_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("c2_req_ready", 32'(req_ready), 32'd0);
        chk("c2_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("c3_req_ready", 32'(req_ready), 32'd0);
        chk("c3_resp_valid", 32'(resp_valid), 32'd1);
        chk("c3_err", 32'(resp_err), 32'd0);
        chk("c3_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        chk("c4_req_ready", 32'(req_ready), 32'd1);
        chk("c4_resp_valid", 32'(resp_valid), 32'd0);

        txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er); chk("lw_init", rd, 32'h12345678);
        txn(1'b1, 32'h11, 32'hAB, 3'b000, rd, er); chk("sb_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er); chk("lw_after_sb", rd, 32'h1234AB78);
        txn(1'b0, 32'h11, 32'h0, 3'b000, rd, er); chk("lb_11", rd, 32'hFFFFFFAB);
        txn(1'b0, 32'h11, 32'h0, 3'b100, rd, er); chk("lbu_11", rd, 32'h000000AB);
        txn(1'b0, 32'h10, 32'h0, 3'b100, rd, er); chk("lbu_10", rd, 32'h00000078);
        txn(1'b1, 32'h12, 32'h8001, 3'b001, rd, er); chk("sh_rdata", rd, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er); chk("lw_after_sh", rd, 32'h8001AB78);
        txn(1'b0, 32'h12, 32'h0, 3'b001, rd, er); chk("lh_12", rd, 32'hFFFF8001);
        txn(1'b0, 32'h12, 32'h0, 3'b101, rd, er); chk("lhu_12", rd, 32'h00008001);
        txn(1'b0, 32'h13, 32'h0, 3'b000, rd, er); chk("lb_13", rd, 32'hFFFFFF80);

        txn(1'b0, 32'h13, 32'h0, 3'b010, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1); chk("lw_mis_rdata", rd, 32'd0);
        txn(1'b1, 32'h11, 32'hFFFF, 3'b001, rd, er); chk("sh_mis_err", 32'(er), 32'd1);
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 3'b100, rd, er); chk("sbu_err", 32'(er), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er); chk("lw_after_errs", rd, 32'h8001AB78);
        txn(1'b0, 32'h1000, 32'h0, 3'b010, rd, er);
        chk("oor_err", 32'(er), 32'd1); chk("oor_rdata", rd, 32'd0);
        txn(1'b0, 32'hFFC, 32'h0, 3'b010, rd, er); chk("last_word_err", 32'(er), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 3'b011, rd, er);
        chk("mop011_err", 32'(er), 32'd1); chk("mop011_rdata", rd, 32'd0);
        txn(1'b0, 32'h12, 32'h0, 3'b101, rd, er); chk("hu_ok_err", 32'(er), 32'd0);

        // Backpressure: req_valid held high, resp_ready low for 5 response cycles
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h10; req_mop = 3'b010;
        chk("bp_accept", 32'(req_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_wait_ready", 32'(req_ready), 32'd0);
            chk("bp_wait_valid", 32'(resp_valid), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h8001AB78);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("bp_second_valid", 32'(resp_valid), 32'd1);
        chk("bp_second_rdata", resp_rdata, 32'h8001AB78);
        @(negedge clk);
        chk("bp_idle", 32'(req_ready), 32'd1);

        // Async reset in the WAIT cycle of a store
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_mop = 3'b010;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("ar_resp_valid", 32'(resp_valid), 32'd0);
        chk("ar_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_still_idle", 32'(resp_valid), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er); chk("ar_lw", rd, 32'h8001AB78);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
